sram_frame_arbiter: RTL and testbench

SRAM_FRAME_ARBITER -- requirements
Module: sram_frame_arbiter

---
 rtl/sram_frame_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sram_frame_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_arbiter.sv
// Purpose: time-slot arbiter sharing one async SRAM between a VGA reader, N_WR writers and an optional background clear, with double-buffered frames (SRAM_BG_FILL_EN adds the clear slot).
// Latency: fixed round of 2-cycle slots; pixel data valid 1 cycle after its read slot, wr_ack 1 cycle after its write slot.
// Backpressure: writers hold wr_valid until wr_ack; a port that is idle at its slot start simply waits a full round.
module sram_frame_arbiter #(
    parameter int N_WR   = 2,
    parameter int DATA_W = 16,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
) (
    input  logic                   sram_clk,
    input  logic                   reset,
    input  logic                   frame_clk,
    input  logic [N_WR-1:0]        wr_valid,
    input  logic [N_WR*X_W-1:0]    wr_x,
    input  logic [N_WR*Y_W-1:0]    wr_y,
    input  logic [N_WR*DATA_W-1:0] wr_data,
    output logic [N_WR-1:0]        wr_ack,
    input  logic [X_W-1:0]         vga_x,
    input  logic [Y_W-1:0]         vga_y,
    output logic [DATA_W-1:0]      vga_data,
    output logic                   vga_valid,
    input  logic [DATA_W-1:0]      bg_data,
    input  logic                   VGA_BLANK_N,
    output logic                   current_frame,
    output logic                   frame_swap,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic [Y_W+X_W:0]       SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ
);

    localparam int AW = 1 + Y_W + X_W;
`ifdef SRAM_BG_FILL_EN
    localparam int N_SLOT = N_WR + 2;
`else
    localparam int N_SLOT = N_WR + 1;
`endif
    localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam logic [SW-1:0] SLOT_VGA  = '0;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLOT - 1);
`ifdef SRAM_BG_FILL_EN
    localparam logic [SW-1:0] SLOT_BG   = SW'(N_WR + 1);
`endif

    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_t;

    phase_t            phase_q, phase_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              act_q, act_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic [N_WR-1:0]   ack_q, ack_d;
    logic              cf_q, cf_d;
    logic              swap_q, swap_d;
    logic              pend_q, pend_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [X_W-1:0]    bg_x_q, bg_x_d;
    logic [Y_W-1:0]    bg_y_q, bg_y_d;
    logic              frame_edge;

    assign frame_edge = sync2_q & ~sync3_q;

`ifndef SRAM_BG_FILL_EN
    logic unused_bg;
    assign unused_bg = ^{bg_data, VGA_BLANK_N, bg_x_q, bg_y_q};
`endif

    // Slot sequencer: close the ending slot, then set up registered SRAM controls for the next one.
    always_comb begin
        phase_d     = phase_q;
        slot_d      = slot_q;
        act_d       = act_q;
        addr_d      = addr_q;
        we_n_d      = 1'b1;
        oe_n_d      = oe_n_q;
        dq_oe_d     = dq_oe_q;
        dq_out_d    = dq_out_q;
        vga_data_d  = vga_data_q;
        vga_valid_d = 1'b0;
        ack_d       = '0;
        cf_d        = cf_q;
        swap_d      = 1'b0;
        pend_d      = pend_q | frame_edge;
        sync1_d     = frame_clk;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        bg_x_d      = bg_x_q;
        bg_y_d      = bg_y_q;

        if (phase_q == PH_A) begin
            phase_d = PH_B;
            // Address and data have been stable for a full cycle; strobe WE_N now.
            if (act_q && slot_q != SLOT_VGA) begin
                we_n_d = 1'b0;
            end
        end else begin
            phase_d = PH_A;
            if (act_q) begin
                if (slot_q == SLOT_VGA) begin
                    vga_data_d  = SRAM_DQ;
                    vga_valid_d = 1'b1;
                end
                for (int i = 0; i < N_WR; i++) begin
                    if (slot_q == SW'(i + 1)) begin
                        ack_d[i] = 1'b1;
                    end
                end
            end

            slot_d  = (slot_q == LAST_SLOT) ? SLOT_VGA : slot_q + 1'b1;
            act_d   = 1'b0;
            oe_n_d  = 1'b1;
            dq_oe_d = 1'b0;

            if (slot_d == SLOT_VGA) begin
                // Round boundary: an edge seen this very cycle waits for the next boundary.
                if (pend_q) begin
                    cf_d   = ~cf_q;
                    swap_d = 1'b1;
                end
                pend_d = frame_edge;
                act_d  = 1'b1;
                oe_n_d = 1'b0;
                addr_d = {cf_d, vga_y, vga_x};
                bg_x_d = vga_x;
                bg_y_d = vga_y;
            end
            for (int i = 0; i < N_WR; i++) begin
                if (slot_d == SW'(i + 1) && wr_valid[i]) begin
                    act_d    = 1'b1;
                    dq_oe_d  = 1'b1;
                    dq_out_d = wr_data[i*DATA_W +: DATA_W];
                    addr_d   = {~cf_q, wr_y[i*Y_W +: Y_W], wr_x[i*X_W +: X_W]};
                end
            end
`ifdef SRAM_BG_FILL_EN
            // Clear the pixel just displayed, only during active video.
            if (slot_d == SLOT_BG && VGA_BLANK_N) begin
                act_d    = 1'b1;
                dq_oe_d  = 1'b1;
                dq_out_d = bg_data;
                addr_d   = {cf_q, bg_y_q, bg_x_q};
            end
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            phase_q     <= PH_A;
            slot_q      <= SLOT_VGA;
            act_q       <= 1'b0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            ack_q       <= '0;
            cf_q        <= 1'b0;
            swap_q      <= 1'b0;
            pend_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            bg_x_q      <= '0;
            bg_y_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            act_q       <= act_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
            vga_data_q  <= vga_data_d;
            vga_valid_q <= vga_valid_d;
            ack_q       <= ack_d;
            cf_q        <= cf_d;
            swap_q      <= swap_d;
            pend_q      <= pend_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            bg_x_q      <= bg_x_d;
            bg_y_q      <= bg_y_d;
        end
    end

    assign SRAM_CE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign SRAM_OE_N     = oe_n_q;
    assign SRAM_WE_N     = we_n_q;
    assign SRAM_ADDR     = addr_q;
    assign SRAM_DQ       = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign vga_data      = vga_data_q;
    assign vga_valid     = vga_valid_q;
    assign wr_ack        = ack_q;
    assign current_frame = cf_q;
    assign frame_swap    = swap_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
module tb_sram_frame_arbiter;
    localparam int N_WR = 2;
    localparam int DW   = 16;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int AW   = 20;
`ifdef SRAM_BG_FILL_EN
    localparam int R = 8;
`else
    localparam int R = 6;
`endif

    logic              clk;
    logic              reset;
    logic              frame_clk;
    logic [N_WR-1:0]   wr_valid;
    logic [N_WR*XW-1:0] wr_x;
    logic [N_WR*YW-1:0] wr_y;
    logic [N_WR*DW-1:0] wr_data;
    logic [N_WR-1:0]   wr_ack;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [DW-1:0]     vga_data;
    logic              vga_valid;
    logic [DW-1:0]     bg_data;
    logic              blank_n;
    logic              current_frame, frame_swap;
    logic              sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n;
    logic [AW-1:0]     sram_addr;
    wire  [DW-1:0]     sram_dq;

    logic [DW-1:0]     mem [0:(1<<AW)-1];
    logic [DW-1:0]     rd_val;
    logic [AW+DW-1:0]  exp_wr [$];
    logic [DW-1:0]     exp_rd [$];
    logic [AW+DW-1:0]  e_wr;
    logic [DW-1:0]     e_rd;
    logic              exp_cf;
    int                total, bad, cyc;

    sram_frame_arbiter #(.N_WR(N_WR), .DATA_W(DW), .X_W(XW), .Y_W(YW)) dut (
        .sram_clk(clk), .reset(reset), .frame_clk(frame_clk),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
        .vga_x(vga_x), .vga_y(vga_y), .vga_data(vga_data), .vga_valid(vga_valid),
        .bg_data(bg_data), .VGA_BLANK_N(blank_n),
        .current_frame(current_frame), .frame_swap(frame_swap),
        .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
        .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SRAM model: drives the bus whenever output enable is low.
    assign rd_val  = mem[sram_addr];
    assign sram_dq = (!sram_oe_n) ? rd_val : {DW{1'bz}};

    // Write scoreboard: every WE_N-low cycle must match the next expected write.
    always @(negedge clk) begin
        if (sram_we_n === 1'b0) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", sram_addr, sram_dq);
            end else begin
                e_wr = exp_wr.pop_front();
                if ({sram_addr, sram_dq} !== e_wr) begin
                    bad++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             sram_addr, sram_dq, e_wr[AW+DW-1:DW], e_wr[DW-1:0]);
                end
            end
            mem[sram_addr] = sram_dq;
        end
    end

    task automatic wait_vga(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3*R && !ok; i++) begin
            @(negedge clk);
            if (vga_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 7;
        if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n: got %b need 1", sram_we_n); end
        if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL rst_oe_n: got %b need 1", sram_oe_n); end
        if (sram_addr !== '0)   begin bad++; $display("FAIL rst_addr: got %h need 0", sram_addr); end
        if (vga_data !== '0 || vga_valid !== 1'b0) begin bad++; $display("FAIL rst_vga: got %h/%b need 0/0", vga_data, vga_valid); end
        if (wr_ack !== '0)      begin bad++; $display("FAIL rst_ack: got %b need 0", wr_ack); end
        if (current_frame !== 1'b0 || frame_swap !== 1'b0) begin bad++; $display("FAIL rst_frame: got %b/%b need 0/0", current_frame, frame_swap); end
        if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin bad++; $display("FAIL rst_ce: got %b need 000", {sram_ce_n, sram_ub_n, sram_lb_n}); end
        reset = 1'b0;
        exp_cf = 1'b0;
    endtask

    task automatic test_write_port1();
        int n0, n1;
        n0 = 0; n1 = 0;
        wr_x[XW +: XW] = 10'd5;
        wr_y[YW +: YW] = 9'd3;
        wr_data[DW +: DW] = 16'hF800;
        wr_valid = 2'b10;
        exp_wr.push_back({20'h80C05, 16'hF800});
        for (int i = 0; i < 4*R; i++) begin
            @(negedge clk);
            if (wr_ack[0]) n0++;
            if (wr_ack[1]) begin n1++; wr_valid = 2'b00; end
        end
        total += 3;
        if (n1 !== 1) begin bad++; $display("FAIL wr1_ack_count: got %0d need 1", n1); end
        if (n0 !== 0) begin bad++; $display("FAIL wr0_ack_count: got %0d need 0", n0); end
        if (exp_wr.size() !== 0) begin bad++; $display("FAIL wr1_missing: got %0d pending need 0", exp_wr.size()); end
    endtask

    task automatic test_read_bg();
        bit ok;
        mem[20'h00C05] = 16'h07E0;
        vga_x = 10'd5; vga_y = 9'd3; bg_data = 16'h0000; blank_n = 1'b0;
        exp_rd.push_back(16'h07E0);
        wait_vga(ok);
        wait_vga(ok);
        total++;
        e_rd = exp_rd.pop_front();
        if (!ok || vga_data !== e_rd) begin bad++; $display("FAIL vga_read: got %h valid=%b need %h", vga_data, ok, e_rd); end
        blank_n = 1'b1;
`ifdef SRAM_BG_FILL_EN
        exp_wr.push_back({20'h00C05, 16'h0000});
        exp_rd.push_back(16'h0000);
`else
        exp_rd.push_back(16'h07E0);
`endif
        repeat (R) @(negedge clk);
        blank_n = 1'b0;
        total++;
        if (exp_wr.size() !== 0) begin bad++; $display("FAIL bg_missing: got %0d pending need 0", exp_wr.size()); end
        wait_vga(ok);
        total++;
        e_rd = exp_rd.pop_front();
        if (!ok || vga_data !== e_rd) begin bad++; $display("FAIL vga_after_bg: got %h valid=%b need %h", vga_data, ok, e_rd); end
    endtask

    task automatic test_back_to_back();
        int n0, n1, t[3];
        n0 = 0; n1 = 0;
        wr_x[0 +: XW] = 10'd7; wr_y[0 +: YW] = 9'd2; wr_data[0 +: DW] = 16'h1234;
        wr_valid = 2'b01;
        repeat (3) exp_wr.push_back({20'h80807, 16'h1234});
        for (int i = 0; i < 5*R; i++) begin
            @(negedge clk);
            if (wr_ack[1]) n1++;
            if (wr_ack[0]) begin
                if (n0 < 3) t[n0] = cyc;
                n0++;
                if (n0 == 3) wr_valid = 2'b00;
            end
        end
        total += 5;
        if (n0 !== 3) begin bad++; $display("FAIL ack3_count: got %0d need 3", n0); end
        if (n1 !== 0) begin bad++; $display("FAIL ack3_other: got %0d need 0", n1); end
        if (t[1] - t[0] !== R) begin bad++; $display("FAIL ack3_gap1: got %0d need %0d", t[1] - t[0], R); end
        if (t[2] - t[1] !== R) begin bad++; $display("FAIL ack3_gap2: got %0d need %0d", t[2] - t[1], R); end
        if (exp_wr.size() !== 0) begin bad++; $display("FAIL ack3_missing: got %0d pending need 0", exp_wr.size()); end
    endtask

    task automatic test_swap_double();
        bit ok;
        int t0, ts, n;
        n = 0; ts = 0;
        wait_vga(ok);
        repeat (R-4) @(negedge clk);
        frame_clk = 1'b1; t0 = cyc;
        @(negedge clk); frame_clk = 1'b0;
        @(negedge clk); frame_clk = 1'b1;
        @(negedge clk); frame_clk = 1'b0;
        for (int i = 0; i < 4*R; i++) begin
            @(negedge clk);
            if (frame_swap) begin if (n == 0) ts = cyc; n++; end
        end
        exp_cf = ~exp_cf;
        total += 4;
        if (!ok) begin bad++; $display("FAIL swap2_align: vga_valid got none need pulse"); end
        if (n !== 1) begin bad++; $display("FAIL swap2_count: got %0d need 1", n); end
        if (ts - t0 !== R + 2) begin bad++; $display("FAIL swap2_time: got %0d need %0d", ts - t0, R + 2); end
        if (current_frame !== exp_cf) begin bad++; $display("FAIL swap2_frame: got %b need %b", current_frame, exp_cf); end
    endtask

    task automatic test_reset_mid_write();
        bit hit;
        int n;
        hit = 1'b0; n = 0;
        wr_x[0 +: XW] = 10'd9; wr_y[0 +: YW] = 9'd4; wr_data[0 +: DW] = 16'hABCD;
        wr_valid = 2'b01;
        exp_wr.push_back({~exp_cf, 9'd4, 10'd9, 16'hABCD});
        for (int i = 0; i < 2*R && !hit; i++) begin
            @(negedge clk);
            if (sram_we_n === 1'b0) hit = 1'b1;
        end
        reset = 1'b1; wr_valid = 2'b00;
        @(negedge clk);
        total += 6;
        if (!hit) begin bad++; $display("FAIL mid_we_seen: got none need WE_N low"); end
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin bad++; $display("FAIL mid_ctrl: got we=%b oe=%b need 1/1", sram_we_n, sram_oe_n); end
        if (wr_ack !== '0) begin bad++; $display("FAIL mid_ack: got %b need 0", wr_ack); end
        if (sram_addr !== '0) begin bad++; $display("FAIL mid_addr: got %h need 0", sram_addr); end
        if (vga_data !== '0 || vga_valid !== 1'b0) begin bad++; $display("FAIL mid_vga: got %h/%b need 0/0", vga_data, vga_valid); end
        if (current_frame !== 1'b0 || frame_swap !== 1'b0) begin bad++; $display("FAIL mid_frame: got %b/%b need 0/0", current_frame, frame_swap); end
        reset = 1'b0; exp_cf = 1'b0;
        for (int i = 0; i < 3*R; i++) begin
            @(negedge clk);
            if (wr_ack !== '0) n++;
        end
        total++;
        if (n !== 0) begin bad++; $display("FAIL mid_late_ack: got %0d need 0", n); end
    endtask

    task automatic test_swap_coincident();
        bit ok;
        int t0, ts, n;
        n = 0; ts = 0;
        wait_vga(ok);
        repeat (R-5) @(negedge clk);
        frame_clk = 1'b1; t0 = cyc;
        for (int i = 0; i < 4*R; i++) begin
            @(negedge clk);
            if (i == 2) frame_clk = 1'b0;
            if (frame_swap) begin if (n == 0) ts = cyc; n++; end
        end
        exp_cf = ~exp_cf;
        total += 3;
        if (!ok || n !== 1) begin bad++; $display("FAIL swapc_count: got %0d need 1", n); end
        if (ts - t0 !== R + 3) begin bad++; $display("FAIL swapc_time: got %0d need %0d", ts - t0, R + 3); end
        if (current_frame !== exp_cf) begin bad++; $display("FAIL swapc_frame: got %b need %b", current_frame, exp_cf); end
    endtask

    task automatic test_round_length();
        bit ok1, ok2;
        int t1, t2;
        wait_vga(ok1); t1 = cyc;
        wait_vga(ok2); t2 = cyc;
        total++;
        if (!ok1 || !ok2 || t2 - t1 !== R) begin bad++; $display("FAIL round_len: got %0d need %0d", t2 - t1, R); end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; exp_cf = 1'b0;
        reset = 1'b1; frame_clk = 1'b0; wr_valid = '0; wr_x = '0; wr_y = '0; wr_data = '0;
        vga_x = '0; vga_y = '0; bg_data = '0; blank_n = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_write_port1();
        test_read_bg();
        test_back_to_back();
        test_swap_double();
        test_reset_mid_write();
        test_swap_coincident();
        test_round_length();
        repeat (4) @(negedge clk);
        total++;
        if (exp_wr.size() !== 0) begin bad++; $display("FAIL end_pending: got %0d need 0", exp_wr.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
